pwm_cmd_sequencer: RTL
======================

# pwm_cmd_sequencer

Sequencer between the current-loop duty sources and the PWM controller. It owns the bridge enable and brake state machine: idle, bootstrap precharge, run and fault. It selects one of two duty-command streams (FOC core or calibration), holds the accepted command in a shadow register, and releases it to the PWM controller only on the period-start event. It runs a per-period command watchdog and latches faults.

## Interface
- PWM_CHANNEL_NUM, 3, number of half-bridge channels
- PWM_WIDTH, 16, bits per duty word
- PWM_RELOAD, 5000, PWM counter top; maximum legal duty
- BOOT_PERIODS, 16, PWM periods of zero-duty precharge before RUN (≥1)
- WDT_PERIODS, 4, consecutive command-less periods in RUN that trip a fault (≥1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset: synchronous, active-low
- enable  in  1  level; request bridge operation
- cal_sel  in  1  0 = FOC source, 1 = calibration source
- fault_in  in  1  level; external fault (overcurrent, driver fault)
- clear_fault  in  1  pulse; leave FAULT
- period_evt  in  1  one-cycle pulse at PWM counter == 0
- foc_tdata  in  PWM_CHANNEL_NUM*PWM_WIDTH  FOC duty words, channel 0 in LSBs
- foc_tvalid  in  1  FOC word valid
- foc_tready  out  1  FOC word accepted when valid&ready
- cal_tdata  in  PWM_CHANNEL_NUM*PWM_WIDTH  calibration duty words
- cal_tvalid  in  1  calibration word valid
- cal_tready  out  1  calibration ready
- pwm_tdata  out  PWM_CHANNEL_NUM*PWM_WIDTH  duty words to the PWM controller
- pwm_tvalid  out  1  one-cycle load strobe to the PWM controller
- brake  out  1  forces all bridge outputs inactive
- state  out  2  0 IDLE, 1 BOOT, 2 RUN, 3 FAULT
- fault_latched  out  1  high while in FAULT

## Operation
- Reset values: state IDLE; brake 1; pwm_tdata 0; pwm_tvalid 0; foc_tready 0; cal_tready 0; fault_latched 0; pending empty; counters 0.
- Transition priority, highest first: fault_in, watchdog trip, enable low, then the normal transitions.
- IDLE: brake=1. enable=1 → BOOT.
- BOOT: brake=0. Each period_evt emits all-zero duty words (low side on, precharges the bootstrap capacitors) and increments the boot counter. The BOOT_PERIODS-th period_evt moves the block to RUN; pending and the watchdog are cleared on entry to RUN.
- RUN: brake=0.
  - The selected source's tready=1; the other source's tready=0.
  - An accepted word overwrites pending (last write wins) and sets pending valid.
  - On period_evt: if pending is valid, pending is emitted and pending valid is cleared; otherwise nothing is emitted and the PWM holds its previous duty.
- Watchdog: cleared on each accept. On a period_evt with no accept since the previous period_evt it increments. Reaching WDT_PERIODS → FAULT.
- cal_sel change in RUN: pending is discarded and the watchdog is cleared in the same cycle.
- enable=0 in BOOT or RUN → IDLE, with no emission.
- FAULT: brake=1, fault_latched=1, both tready=0. The block returns to IDLE only on clear_fault=1 with fault_in=0 and enable=0; otherwise it stays in FAULT.
- Reset mid-operation returns every output to its reset value on the next edge.

## Timing
- State, brake and tready are registered. A condition sampled at edge N takes effect at the outputs after edge N.
- pwm_tvalid is high for exactly one cycle: the cycle after the period_evt cycle. pwm_tdata is updated on the same edge and then held.
- An accept in the same cycle as period_evt is not emitted in that period. The emission uses the prior pending value; the new word becomes pending for the next period. For the watchdog, that accept counts toward the following period.
- fault_in has one cycle of latency to brake. An emission scheduled on the same edge is suppressed.
- Emission latency from accept is at most one PWM period plus one cycle.

## Configuration
- PWM_SEQ_CLAMP_EN defined: each emitted duty word greater than PWM_RELOAD is replaced by PWM_RELOAD, per channel, at emission.
- PWM_SEQ_CLAMP_EN undefined: duty words pass unmodified.

## Test plan
- Boot sequence: enable=1 after reset, period_evt every 100 cycles → BOOT_PERIODS zero-duty strobes, then state=2 and foc_tready=1. brake falls one cycle after enable is sampled.
- Shadow load: in RUN, accept FOC words 0x0100/0x0200/0x0300 mid-period → a single strobe after the next period_evt carrying the last word (0x0300 pattern). The following period, with no accept, produces no strobe.
- Same-cycle collision: accept word A in the period_evt cycle while pending holds B → emit B; A is emitted one period later.
- Watchdog: in RUN, stop foc_tvalid → state=3 and brake=1 on the WDT_PERIODS-th period_evt plus one cycle. clear_fault with enable=0 → IDLE.
- Fault priority: assert fault_in in BOOT in the period_evt cycle → no strobe and brake=1 next cycle. clear_fault while fault_in=1 → remains in FAULT.
- Clamp: with PWM_SEQ_CLAMP_EN defined, channel 1 = 6000 → emitted channel 1 = 5000. With the macro undefined → emitted channel 1 = 6000.

Source files
------------

// File: rtl/pwm_cmd_sequencer_if.sv
// Duty-command stream bundle: FOC and calibration sources in, PWM load out.
// master = command side / PWM consumer, slave = sequencer.
interface pwm_cmd_sequencer_if #(
  parameter int PWM_CHANNEL_NUM = 3,
  parameter int PWM_WIDTH       = 16
);
  localparam int DW = PWM_CHANNEL_NUM * PWM_WIDTH;

  logic [DW-1:0] foc_tdata;
  logic          foc_tvalid;
  logic          foc_tready;
  logic [DW-1:0] cal_tdata;
  logic          cal_tvalid;
  logic          cal_tready;
  logic [DW-1:0] pwm_tdata;
  logic          pwm_tvalid;

  modport master (
    output foc_tdata, foc_tvalid,
    input  foc_tready,
    output cal_tdata, cal_tvalid,
    input  cal_tready,
    input  pwm_tdata, pwm_tvalid
  );

  modport slave (
    input  foc_tdata, foc_tvalid,
    output foc_tready,
    input  cal_tdata, cal_tvalid,
    output cal_tready,
    output pwm_tdata, pwm_tvalid
  );
endinterface

// File: rtl/pwm_cmd_sequencer.sv
// Bridge enable/brake FSM, duty shadow register and per-period watchdog.
// Ports: clk, rstn (sync, active-low), enable, cal_sel, fault_in,
// clear_fault, period_evt, bus (slave: foc/cal in, pwm out),
// brake, state, fault_latched. Optional clamp: PWM_SEQ_CLAMP_EN.
module pwm_cmd_sequencer #(
  parameter int PWM_CHANNEL_NUM = 3,
  parameter int PWM_WIDTH       = 16,
  parameter int PWM_RELOAD      = 5000,
  parameter int BOOT_PERIODS    = 16,
  parameter int WDT_PERIODS     = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                cal_sel,
  input  logic                fault_in,
  input  logic                clear_fault,
  input  logic                period_evt,
  pwm_cmd_sequencer_if.slave  bus,
  output logic                brake,
  output logic [1:0]          state,
  output logic                fault_latched
);

  localparam int DW = PWM_CHANNEL_NUM * PWM_WIDTH;
  localparam int BW = $clog2(BOOT_PERIODS + 1);
  localparam int WW = $clog2(WDT_PERIODS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BOOT  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } st_t;

  st_t           st_q, st_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [WW-1:0] wdt_q, wdt_d;
  logic          seen_q, seen_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pv_q, pv_d;
  logic          sel_q;
  logic          emit;
  logic [DW-1:0] emit_data;

  logic          foc_acc;
  logic          cal_acc;
  logic          acc;
  logic [DW-1:0] acc_data;
  logic          sel_chg;
  logic          trip;

  function automatic logic [DW-1:0] shape(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef PWM_SEQ_CLAMP_EN
    for (int c = 0; c < PWM_CHANNEL_NUM; c++) begin
      if (d[c*PWM_WIDTH +: PWM_WIDTH] > PWM_WIDTH'(PWM_RELOAD))
        r[c*PWM_WIDTH +: PWM_WIDTH] = PWM_WIDTH'(PWM_RELOAD);
    end
`endif
    return r;
  endfunction

  assign foc_acc  = bus.foc_tvalid & bus.foc_tready;
  assign cal_acc  = bus.cal_tvalid & bus.cal_tready;
  assign acc      = foc_acc | cal_acc;
  assign acc_data = foc_acc ? bus.foc_tdata : bus.cal_tdata;
  assign sel_chg  = cal_sel != sel_q;

  // seen_q: an accept landed since the previous period_evt
  assign trip = period_evt && !seen_q &&
                (wdt_q == WW'(WDT_PERIODS - 1));

  always_comb begin
    st_d      = st_q;
    boot_d    = boot_q;
    wdt_d     = wdt_q;
    seen_d    = seen_q;
    pend_d    = pend_q;
    pv_d      = pv_q;
    emit      = 1'b0;
    emit_data = pend_q;

    unique case (st_q)
      S_IDLE: begin
        if (fault_in) begin
          st_d = S_FAULT;
        end else if (enable) begin
          st_d   = S_BOOT;
          boot_d = '0;
        end
      end
      S_BOOT: begin
        if (fault_in) begin
          st_d = S_FAULT;
        end else if (!enable) begin
          st_d = S_IDLE;
        end else if (period_evt) begin
          emit      = 1'b1;
          emit_data = '0;
          boot_d    = boot_q + 1'b1;
          if (boot_q == BW'(BOOT_PERIODS - 1))
            st_d = S_RUN;
        end
      end
      S_RUN: begin
        if (fault_in || trip) begin
          st_d = S_FAULT;
        end else if (!enable) begin
          st_d = S_IDLE;
        end else if (sel_chg) begin
          // stale command from the old source is dropped
          pv_d   = 1'b0;
          wdt_d  = '0;
          seen_d = 1'b0;
        end else begin
          if (period_evt) begin
            emit   = pv_q;
            pv_d   = 1'b0;
            wdt_d  = seen_q ? '0 : wdt_q + 1'b1;
            seen_d = 1'b0;
          end
          // same-cycle accept is shadowed for the next period
          if (acc) begin
            pend_d = acc_data;
            pv_d   = 1'b1;
            seen_d = 1'b1;
            if (!period_evt)
              wdt_d = '0;
          end
        end
      end
      S_FAULT: begin
        if (clear_fault && !fault_in && !enable)
          st_d = S_IDLE;
      end
    endcase

    if (st_d != S_RUN || st_q != S_RUN) begin
      if (st_d != st_q) begin
        pv_d   = 1'b0;
        wdt_d  = '0;
        seen_d = 1'b0;
      end
    end
    if (st_d != S_BOOT)
      boot_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q           <= S_IDLE;
      boot_q         <= '0;
      wdt_q          <= '0;
      seen_q         <= 1'b0;
      pend_q         <= '0;
      pv_q           <= 1'b0;
      sel_q          <= 1'b0;
      brake          <= 1'b1;
      fault_latched  <= 1'b0;
      bus.foc_tready <= 1'b0;
      bus.cal_tready <= 1'b0;
      bus.pwm_tvalid <= 1'b0;
      bus.pwm_tdata  <= '0;
    end else begin
      st_q           <= st_d;
      boot_q         <= boot_d;
      wdt_q          <= wdt_d;
      seen_q         <= seen_d;
      pend_q         <= pend_d;
      pv_q           <= pv_d;
      sel_q          <= cal_sel;
      brake          <= (st_d == S_IDLE) || (st_d == S_FAULT);
      fault_latched  <= st_d == S_FAULT;
      bus.foc_tready <= (st_d == S_RUN) && !cal_sel;
      bus.cal_tready <= (st_d == S_RUN) && cal_sel;
      bus.pwm_tvalid <= emit;
      if (emit)
        bus.pwm_tdata <= shape(emit_data);
    end
  end

  assign state = st_q;

endmodule
